// File: rtl/prewish_pkg.sv
// prewish_pkg: shared FSM encoding and button width for the debounce poller.
package prewish_pkg;
  localparam int PREWISH_DW = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, STROBE = 2'b01, WAIT = 2'b11} state_e;
endpackage

// File: rtl/prewish_tick_div.sv
// prewish_tick_div: 50% duty slow clock of period 2*DIV with a one-cycle pulse on each rising toggle.
module prewish_tick_div #(
  parameter int unsigned DIV = 6000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic clk_o,
  output logic rise_o
);
  logic [15:0] cnt_q, cnt_d;
  logic clk_q, clk_d, wrap;
  always_comb begin
    wrap = cnt_q == 16'(DIV - 1);
    cnt_d = wrap ? '0 : cnt_q + 16'd1;
    clk_d = clk_q ^ wrap;
  end
  assign rise_o = wrap & ~clk_q;
  assign clk_o = clk_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end
endmodule

// File: rtl/prewish_debounce_poller.sv
// prewish_debounce_poller: polls the debounce block via strobe handshake and publishes buttons with rise/fall pulses.
// Optional reply timeout enabled by defining PREWISH_POLLER_TIMEOUT_EN.
module prewish_debounce_poller
  import prewish_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 6000,
  parameter int unsigned POLL_TICKS = 8,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned DW         = PREWISH_DW
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  output logic          o_dbclock,
  output logic          STB_O,
  input  logic          DB_STB_I,
  input  logic [DW-1:0] DB_DAT_I,
  input  logic          i_enable,
  input  logic          i_poll_now,
  output logic [DW-1:0] o_buttons,
  output logic [DW-1:0] o_rose,
  output logic [DW-1:0] o_fell,
  output logic          o_changed,
  output logic          o_timeout,
  output logic          o_busy
);
  state_e state_q, state_d;
  logic [7:0] poll_q, poll_d;
  logic pend_q, pend_d, chg_q, chg_d;
  logic [DW-1:0] btn_q, btn_d, rose_q, rose_d, fell_q, fell_d;
  logic tick_rise, auto_trig, trig, capture, tmo_done;
  prewish_tick_div #(.DIV(TICK_DIV)) u_tick (
    .clk_i (CLK_I),
    .rst_ni(RST_I),
    .clk_o (o_dbclock),
    .rise_o(tick_rise)
  );
  always_comb begin
    auto_trig = tick_rise & i_enable & (poll_q == 8'(POLL_TICKS - 1));
    poll_d = (tick_rise & i_enable) ? (auto_trig ? '0 : poll_q + 8'd1) : poll_q;
    trig = auto_trig | i_poll_now;
    capture = (state_q == WAIT) & DB_STB_I;
    pend_d = (state_q != IDLE) & (pend_q | trig);
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig | pend_q) state_d = STROBE;
      STROBE:  state_d = WAIT;
      WAIT:    if (capture | tmo_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    btn_d = capture ? DB_DAT_I : btn_q;
    rose_d = capture ? DB_DAT_I & ~btn_q : '0;
    fell_d = capture ? ~DB_DAT_I & btn_q : '0;
    chg_d = capture & (DB_DAT_I != btn_q);
  end
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      poll_q <= '0;
      pend_q <= 1'b0;
      btn_q <= '0;
      rose_q <= '0;
      fell_q <= '0;
      chg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q <= poll_d;
      pend_q <= pend_d;
      btn_q <= btn_d;
      rose_q <= rose_d;
      fell_q <= fell_d;
      chg_q <= chg_d;
    end
  end
`ifdef PREWISH_POLLER_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic tout_q;
  // Counter is loaded while strobing so WAIT lasts exactly TIMEOUT cycles.
  assign tmo_done = (state_q == WAIT) & ~DB_STB_I & (tmo_q == 8'd1);
  assign tmo_d = (state_q == STROBE) ? 8'(TIMEOUT) : (state_q == WAIT) ? tmo_q - 8'd1 : tmo_q;
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      tmo_q <= '0;
      tout_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      tout_q <= tmo_done;
    end
  end
  assign o_timeout = tout_q;
`else
  assign tmo_done = 1'b0;
  assign o_timeout = 1'b0 & |TIMEOUT;
`endif
  assign STB_O = state_q == STROBE;
  assign o_busy = state_q != IDLE;
  assign o_buttons = btn_q;
  assign o_rose = rose_q;
  assign o_fell = fell_q;
  assign o_changed = chg_q;
endmodule

// File: tb/tb_prewish_debounce_poller.sv
// tb_prewish_debounce_poller: directed bench with a reply model and capture scoreboard.
module tb_prewish_debounce_poller;
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] r;
    logic [7:0] f;
    logic       c;
  } cap_t;
  typedef struct packed {
    cap_t        cap;
    logic [16:0] after;
  } obs_t;
  logic clk = 0, rst_n = 0, i_enable = 0, i_poll_now = 0;
  logic r_stb = 0, s_stb = 0, reply_on = 0;
  logic [7:0] r_dat = 0, s_dat = 0, reply_val = 0, model = 0;
  logic o_dbclock, STB_O, o_changed, o_timeout, o_busy;
  logic [7:0] o_buttons, o_rose, o_fell;
  int cyc = 0, errs = 0, chks = 0, rd = 0, reply_dly = 3, wcnt = 0, chk_st = 0;
  cap_t exp_q[$];
  obs_t obs_q[$];
  obs_t o;
  prewish_debounce_poller #(.TICK_DIV(4), .POLL_TICKS(2), .TIMEOUT(15), .DW(8)) dut (
    .CLK_I(clk),
    .RST_I(rst_n),
    .o_dbclock(o_dbclock),
    .STB_O(STB_O),
    .DB_STB_I(r_stb | s_stb),
    .DB_DAT_I(r_stb ? r_dat : s_dat),
    .i_enable(i_enable),
    .i_poll_now(i_poll_now),
    .o_buttons(o_buttons),
    .o_rose(o_rose),
    .o_fell(o_fell),
    .o_changed(o_changed),
    .o_timeout(o_timeout),
    .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Debounce-block model: replies reply_dly cycles after the strobe cycle and records what the DUT publishes.
  always @(negedge clk) begin
    r_stb = 0;
    if (!rst_n) begin
      wcnt = 0;
      chk_st = 0;
      model = 0;
    end else begin
      if (chk_st == 2) begin
        o.after = {o_rose, o_fell, o_changed};
        obs_q.push_back(o);
        chk_st = 0;
      end
      if (chk_st == 1) begin
        o.cap = {o_buttons, o_rose, o_fell, o_changed};
        chk_st = 2;
      end
      if (STB_O) wcnt = reply_dly;
      else if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0 && reply_on) begin
          r_stb = 1;
          r_dat = reply_val;
          exp_q.push_back({reply_val, reply_val & ~model, ~reply_val & model, reply_val != model});
          model = reply_val;
          chk_st = 1;
        end
      end
    end
  end
  task automatic chk(input logic [63:0] got, input logic [63:0] want, input string tag);
    chks++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic check_caps();
    while (rd < obs_q.size()) begin
      if (rd < exp_q.size()) chk(64'(obs_q[rd].cap), 64'(exp_q[rd]), "capture");
      else chk(64'(rd), 64'(exp_q.size()), "capture_unexpected");
      chk(64'(obs_q[rd].after), 64'd0, "pulse_width");
      rd++;
    end
  endtask
  task automatic wait_stb(input int max, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (!STB_O && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(64'(STB_O), 64'd1, "stb_wait");
    t = cyc;
  endtask
  task automatic poll_now();
    i_poll_now = 1;
    @(negedge clk);
    i_poll_now = 0;
  endtask
  initial begin
    int t1, t2, n, hi;
    repeat (3) @(negedge clk);
    chk({STB_O, o_busy, o_buttons, o_rose, o_fell, o_changed, o_timeout, o_dbclock}, 0, "reset_state");
    rst_n = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk(64'(o_dbclock), 64'((i / 4) % 2), "dbclock");
    end
    chk({STB_O, o_busy, o_buttons, o_rose, o_fell, o_changed, o_timeout}, 0, "idle_outputs");
    reply_val = 8'h05;
    reply_on = 1;
    i_enable = 1;
    wait_stb(64, t1);
    @(negedge clk);
    chk(64'(STB_O), 64'd0, "stb_one_cycle");
    wait_stb(64, t2);
    chk(64'(t2 - t1), 64'd16, "poll_period");
    repeat (8) @(negedge clk);
    chk(64'(obs_q.size()), 64'd2, "captures_auto");
    chk(64'(o_buttons), 64'h05, "buttons_05");
    check_caps();
    reply_val = 8'h0C;
    wait_stb(64, t1);
    repeat (8) @(negedge clk);
    i_enable = 0;
    chk(64'(obs_q.size()), 64'd3, "captures_change");
    check_caps();
    n = 0;
    while (o_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(64'(o_busy), 64'd0, "idle_wait");
    reply_dly = 6;
    repeat (2) @(negedge clk);
    t1 = cyc;
    poll_now();
    chk(64'(STB_O), 64'd1, "poll_now_latency");
    chk(64'(cyc - t1), 64'd1, "poll_now_cycle");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_poll_now = 1;
      @(negedge clk);
      i_poll_now = 0;
    end
    @(negedge clk);
    chk({STB_O, o_busy}, 0, "idle_reentered");
    @(negedge clk);
    chk(64'(STB_O), 64'd1, "pending_strobe");
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      hi += int'(STB_O);
    end
    chk(64'(hi), 64'd0, "coalesced");
    chk(64'(obs_q.size()), 64'd5, "captures_poll");
    check_caps();
    reply_on = 0;
    reply_dly = 3;
    poll_now();
    t1 = cyc;
    repeat (15) @(negedge clk);
    chk({o_timeout, o_busy}, 64'b01, "wait_before_timeout");
    @(negedge clk);
`ifdef PREWISH_POLLER_TIMEOUT_EN
    chk({o_timeout, o_busy, o_buttons}, {2'b10, 8'h0C}, "timeout_pulse");
    @(negedge clk);
    chk(64'(o_timeout), 64'd0, "timeout_one_cycle");
`else
    chk({o_timeout, o_busy, o_buttons}, {2'b01, 8'h0C}, "no_timeout_hold");
    repeat (20) @(negedge clk);
    chk({o_timeout, o_busy}, 64'b01, "busy_held");
`endif
    if (!o_busy) begin
      poll_now();
      @(negedge clk);
    end
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk({STB_O, o_busy, o_buttons}, 0, "async_reset");
    @(negedge clk);
    rst_n = 1;
    s_dat = 8'hFF;
    s_stb = 1;
    @(negedge clk);
    s_stb = 0;
    @(negedge clk);
    chk({STB_O, o_busy, o_buttons, o_rose, o_changed}, 0, "late_reply_ignored");
    check_caps();
    chk(64'(obs_q.size()), 64'd5, "captures_total");
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
